// File: rtl/uart_rx_os_if.sv
// uart_rx_os bus: serial input, tick and received-word outputs.
// UART_RX_PARITY_EN adds the parity_err signal.
interface uart_rx_os_if #(
  parameter int D_BIT = 8
);
  logic             rx;
  logic             s_tick;
  logic [D_BIT-1:0] dout;
  logic             rx_done_tick;
  logic             frame_err;
`ifdef UART_RX_PARITY_EN
  logic             parity_err;
`endif

  modport master (
    input  rx,
    input  s_tick,
    output dout,
    output rx_done_tick,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output frame_err
  );

  modport slave (
    output rx,
    output s_tick,
    input  dout,
    input  rx_done_tick,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  frame_err
  );
endinterface

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with stop-bit check.
// UART_RX_PARITY_EN adds an even-parity bit and parity_err.
module uart_rx_os #(
  parameter int D_BIT   = 8,
  parameter int SB_TICK = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_os_if.master  bus
);
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (D_BIT > 1) ? $clog2(D_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q;
  logic [1:0]       sync_q;
  logic [SW-1:0]    s_cnt_q;
  logic [NW-1:0]    n_cnt_q;
  logic [D_BIT-1:0] b_q;
  logic [D_BIT-1:0] dout_q;
  logic             done_q;
  logic             ferr_q;
  logic             rx_s;
`ifdef UART_RX_PARITY_EN
  logic             par_q;
  logic             perr_q;
`endif

  assign rx_s             = sync_q[1];
  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_q;
`endif

  // two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.rx};
    end
  end

  // receive FSM with counters, shifter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            s_cnt_q <= '0;
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (s_cnt_q == SW'(7)) begin
              if (!rx_s) begin
                state_q <= DATA;
                s_cnt_q <= '0;
                n_cnt_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s_cnt_q == SW'(15)) begin
              s_cnt_q <= '0;
              b_q     <= {rx_s, b_q[D_BIT-1:1]};
              if (n_cnt_q == NW'(D_BIT-1)) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                n_cnt_q <= n_cnt_q + 1'b1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bus.s_tick) begin
            if (s_cnt_q == SW'(15)) begin
              s_cnt_q <= '0;
              par_q   <= rx_s;
              state_q <= STOP;
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (bus.s_tick) begin
            if (s_cnt_q == SW'(SB_TICK-1)) begin
              dout_q  <= b_q;
              ferr_q  <= ~rx_s;
              done_q  <= 1'b1;
              state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
              perr_q  <= (^b_q) ^ par_q;
`endif
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: frame table plus glitch, reset and
// back-to-back sequences, checked through a scoreboard.
module tb_uart_rx_os;
  localparam int BITC = 64;
`ifdef UART_RX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic clk;
  logic rst;
  uart_rx_os_if #(.D_BIT(8)) bus ();

  uart_rx_os #(.D_BIT(8), .SB_TICK(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  exp_t sb[$];
  vec_t tv[5];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   prev_cyc = 0;
  logic prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // tick every 4 clocks, driven on the falling edge
  initial begin
    int ph;
    ph = 0;
    bus.s_tick = 1'b0;
    forever begin
      @(negedge clk);
      bus.s_tick = (ph == 3);
      ph = (ph == 3) ? 0 : ph + 1;
    end
  end

  // output monitor: pops the scoreboard on each done pulse
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (bus.rx_done_tick === 1'b1) begin
      chk("pulse_width", {31'd0, prev_done}, 32'd0);
      done_cnt++;
      prev_cyc = last_cyc;
      last_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done dout %0h", bus.dout);
      end else begin
        e = sb.pop_front();
        chk("dout", {24'd0, bus.dout}, {24'd0, e.d});
        chk("frame_err", {31'd0, bus.frame_err}, {31'd0, e.fe});
`ifdef UART_RX_PARITY_EN
        chk("parity_err", {31'd0, bus.parity_err}, {31'd0, e.pe});
`endif
      end
    end
    prev_done = bus.rx_done_tick;
  end

  task automatic send_bit(input logic b, input int n);
    bus.rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input logic par);
    send_bit(1'b0, BITC);
    for (int i = 0; i < 8; i++) send_bit(d[i], BITC);
`ifdef UART_RX_PARITY_EN
    send_bit(par, BITC);
`else
    if (par === 1'bx) send_bit(1'b1, 1);
`endif
    if (stop) begin
      send_bit(1'b1, BITC);
    end else begin
      // low only past the mid-bit sample so the restarted
      // start check sees the line high again
      send_bit(1'b0, 40);
      send_bit(1'b1, BITC - 40);
    end
  endtask

  task automatic push(input logic [7:0] d,
                      input logic fe,
                      input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    sb.push_back(e);
  endtask

  initial begin
    int n0;
    tv[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    tv[1] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    tv[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tv[3] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tv[4] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1};

    bus.rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_dout", {24'd0, bus.dout}, 32'd0);
    chk("rst_done", {31'd0, bus.rx_done_tick}, 32'd0);
    chk("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
`ifdef UART_RX_PARITY_EN
    chk("rst_perr", {31'd0, bus.parity_err}, 32'd0);
`endif
    send_bit(1'b1, 2 * BITC);

    for (int i = 0; i < 5; i++) begin
      n0 = done_cnt;
      push(tv[i].exp_d, tv[i].exp_fe, tv[i].exp_pe);
      send_frame(tv[i].data, tv[i].stop, tv[i].par);
      send_bit(1'b1, 2 * BITC);
      chk("frame_cnt", done_cnt, n0 + 1);
    end

    n0 = done_cnt;
    send_bit(1'b0, 12);
    send_bit(1'b1, 4 * BITC);
    chk("glitch_cnt", done_cnt, n0);
    push(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, ^8'h55);
    send_bit(1'b1, 2 * BITC);
    chk("after_glitch", done_cnt, n0 + 1);

    n0 = done_cnt;
    send_bit(1'b0, BITC);
    send_bit(1'b1, 4 * BITC);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_bit(1'b1, 7 * BITC);
    chk("rst_mid_cnt", done_cnt, n0);
    chk("rst_mid_dout", {24'd0, bus.dout}, 32'd0);
    chk("rst_mid_ferr", {31'd0, bus.frame_err}, 32'd0);
    push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, ^8'h81);
    send_bit(1'b1, 2 * BITC);
    chk("after_rst", done_cnt, n0 + 1);

    n0 = done_cnt;
    push(8'h00, 1'b0, 1'b0);
    push(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_bit(1'b1, 2 * BITC);
    chk("b2b_cnt", done_cnt, n0 + 2);
    chk("b2b_gap", last_cyc - prev_cyc, FBITS * BITC);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver for the UART module: recovers serial frames from the `rx` line and presents each received word on a parallel bus.
- Samples `rx` on a 16x baud tick from the baud-rate generator, which is built on the loadable counter register.
- Synchronises `rx` internally and checks the stop bit.
- Signals each completed frame with a one-cycle `rx_done_tick` for the FIFO/interface logic.

## Interface
- `D_BIT`, 8: data bits per frame, LSB first.
- `SB_TICK`, 16: oversampling ticks spanning the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `s_tick`  input  1  single-cycle enable pulse at 16x baud rate.
- `rx`  input  1  serial line, idle high, asynchronous to `clk`.
- `dout`  output  D_BIT  last received data word.
- `rx_done_tick`  output  1  one-cycle pulse: `dout` and `frame_err` updated this cycle.
- `frame_err`  output  1  stop bit of the last frame sampled low.
- `parity_err`  output  1  present only with `UART_RX_PARITY_EN`; parity mismatch on the last frame.

One clock; reset is synchronous and active-high (`clk`, `rst`).

## Operation
- **Input synchroniser**
  - `rx` passes through two flip-flops, reset value 1; FSM uses the second stage, `rx_s`.
- **Counters**
  - `s_cnt` (4 bits, wide enough for SB_TICK-1) counts ticks within a bit.
  - `n_cnt` (clog2(D_BIT) bits) counts data bits.
  - Shift register `b_reg` (D_BIT bits) collects data.
- **FSM states and transitions**
  - IDLE: if `rx_s`==0, go to START and clear `s_cnt`. Independent of `s_tick`.
  - START: on `s_tick`, increment `s_cnt`. At `s_cnt`==7 (mid start bit):
    - `rx_s`==0: go to DATA and clear `s_cnt` and `n_cnt`.
    - `rx_s`==1: glitch; go to IDLE with no output activity.
  - DATA: on `s_tick`, increment `s_cnt`. At `s_cnt`==15:
    - Clear `s_cnt` and shift `b_reg` <= {`rx_s`, `b_reg`[D_BIT-1:1]}.
    - If `n_cnt`==D_BIT-1, go to STOP (PARITY when enabled); else increment `n_cnt`.
  - STOP: on `s_tick`, increment `s_cnt`. At `s_cnt`==SB_TICK-1:
    - Load `dout` <= `b_reg` and `frame_err` <= ~`rx_s`.
    - Pulse `rx_done_tick`; go to IDLE.
- **No-tick cycles**
  - Outside IDLE, cycles without `s_tick` hold all state.
- **Errored frames**
  - A frame with a bad stop bit still updates `dout` and asserts `rx_done_tick`, with `frame_err`=1.
- **Output hold**
  - `dout`, `frame_err` and `parity_err` hold until the next `rx_done_tick`.
- **Reset mid-frame**
  - Returns to IDLE and discards the partial word; no `rx_done_tick`.
  - `dout` is cleared to 0.
- **Line held low**
  - A continuous low `rx` (break) produces a frame of all zeros with `frame_err`=1.
  - The receiver then re-enters START immediately from IDLE.

## Timing
- **Reset values**
  - Outputs: `dout`=0, `rx_done_tick`=0, `frame_err`=0, `parity_err`=0.
  - Internal: state IDLE, counters 0, synchroniser flops 1.
- **Start detect**
  - The FSM sees a falling edge on `rx` 2 clocks after the line changes.
- **Frame latency**
  - From IDLE exit: 8 + 16·D_BIT (+16 with parity) + SB_TICK `s_tick` pulses.
  - `rx_done_tick` and the outputs are registered; they assert in the clock cycle following the clock edge that samples the final stop tick.
- **Pulse width**
  - `rx_done_tick` is high for exactly one `clk` cycle regardless of tick spacing.
- **Back-to-back frames**
  - A start bit immediately following the stop-bit sample is accepted, because IDLE transitions without waiting for a tick.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP.
  - On `s_tick` at `s_cnt`==15, sample `rx_s` into a parity flop.
  - `parity_err` <= (^`b_reg`) ^ parity bit (even parity), updated with `rx_done_tick`.
  - `parity_err` port exists.
- Undefined: no PARITY state; the frame is start + D_BIT + stop; `parity_err` port absent.

## Test plan
- Defaults, `s_tick` every 4 clocks; send 0xA5 (LSB first, stop=1) -> one `rx_done_tick`, `dout`=0xA5, `frame_err`=0.
- Send 0x3C with stop bit driven 0 -> `rx_done_tick`, `dout`=0x3C, `frame_err`=1; the next good frame 0x01 clears `frame_err`.
- Pulse `rx` low for 3 ticks, then high -> no `rx_done_tick`; FSM returns to IDLE; a subsequent 0x55 is received correctly.
- Assert `rst` for 2 cycles midway through the data bits of 0xFF -> no `rx_done_tick`, `dout`=0; the next frame 0x81 is received correctly.
- Back-to-back 0x00 then 0xFF with no idle gap -> two `rx_done_tick` pulses 160 ticks apart (8-bit frame, 1 stop bit), `dout` 0x00 then 0xFF.
- With `UART_RX_PARITY_EN`: send 0x07 with parity 1 -> `parity_err`=0; with parity 0 -> `parity_err`=1.
